// File: rtl/manual_drive_ctrl_pkg.sv
// Shared encodings for the manual drive controller.
package manual_drive_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_NOT_STARTING = 2'b00,
    ST_STARTING     = 2'b01,
    ST_MOVING       = 2'b10
  } drive_state_e;

  // Bit positions inside moving_state
  localparam int unsigned MV_FWD   = 0;
  localparam int unsigned MV_BACK  = 1;
  localparam int unsigned MV_LEFT  = 2;
  localparam int unsigned MV_RIGHT = 3;

  // One-hot panel encoding of a drive state
  function automatic logic [2:0] state_onehot(input drive_state_e s);
    logic [2:0] oh;
    oh = 3'b000;
    case (s)
      ST_NOT_STARTING: oh = 3'b001;
      ST_STARTING:     oh = 3'b010;
      ST_MOVING:       oh = 3'b100;
      default:         oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/manual_drive_ctrl_power_engine.sv
// Engine power register with long-press power-up, power-off and stall shutdown.
module manual_drive_ctrl_power_engine #(
  parameter int unsigned LONG_PRESS_CYCLES = 100_000_000
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic power_on,
  input  logic power_off,
  input  logic stall,
  output logic power
);

  localparam int unsigned CntW = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LONG_PRESS_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            power_q, power_d;

  // Next power state; power_off outranks everything, the press counter only runs while off
  always_comb begin
    power_d = power_q;
    cnt_d   = cnt_q;
    if (power_off) begin
      power_d = 1'b0;
      cnt_d   = '0;
    end else if (power_q) begin
      cnt_d = '0;
      if (stall) power_d = 1'b0;
    end else if (power_on) begin
      if (cnt_q == CntLast) begin
        power_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Power and press-counter registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      power_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      power_q <= power_d;
      cnt_q   <= cnt_d;
    end
  end

  assign power = power_q;

endmodule

// File: rtl/manual_drive_ctrl.sv
// Power and manual-transmission controller: drive FSM, moving nibble and panel lights.
module manual_drive_ctrl
  import manual_drive_ctrl_pkg::*;
#(
  parameter int unsigned LONG_PRESS_CYCLES = 100_000_000,
  parameter int unsigned BLINK_HALF_CYCLES = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic       power_off,
  input  logic       clutch,
  input  logic       throttle,
  input  logic       brake,
  input  logic       rgs,
  input  logic       left,
  input  logic       right,
  output logic       power,
  output logic [1:0] state,
  output logic [3:0] moving_state,
  output logic       power_light,
  output logic [2:0] state_light,
  output logic [3:0] moving_light,
  output logic       turn_left_light,
  output logic       turn_right_light
);

  localparam int unsigned BlinkW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_CYCLES - 1);

  drive_state_e      state_q, state_d;
  logic [3:0]        moving_q, moving_d;
  logic              rgs_q;
  logic              left_q, right_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_q;
  logic              stall_cond;
  logic              stall_req;

  manual_drive_ctrl_power_engine #(
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_power_engine (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .power_on (power_on),
    .power_off(power_off),
    .stall    (stall_req),
    .power    (power)
  );

  // Stall detection: throttle without clutch at rest, or a gear change without clutch when rolling
  always_comb begin
    stall_cond = 1'b0;
    case (state_q)
      ST_NOT_STARTING:       stall_cond = throttle & ~clutch;
      ST_STARTING, ST_MOVING: stall_cond = (rgs != rgs_q) & ~clutch;
      default:               stall_cond = 1'b0;
    endcase
    stall_req = power & stall_cond;
  end

  // Drive-state transitions and the moving nibble for the next state
  always_comb begin
    state_d  = state_q;
    moving_d = 4'b0000;
    if (!power || power_off || stall_req || brake) begin
      state_d = ST_NOT_STARTING;
    end else begin
      case (state_q)
        ST_NOT_STARTING: if (throttle && clutch)    state_d = ST_STARTING;
        ST_STARTING:     if (throttle && !clutch)   state_d = ST_MOVING;
        ST_MOVING:       if (clutch || !throttle)   state_d = ST_STARTING;
        default:                                    state_d = ST_NOT_STARTING;
      endcase
    end
    if (state_d == ST_MOVING) begin
      moving_d[MV_FWD]   = ~rgs;
      moving_d[MV_BACK]  = rgs;
      moving_d[MV_LEFT]  = left & ~right;
      moving_d[MV_RIGHT] = right & ~left;
    end
  end

  // Drive state, moving nibble and input history registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_NOT_STARTING;
      moving_q <= 4'b0000;
      rgs_q    <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      moving_q <= moving_d;
      rgs_q    <= rgs;
      left_q   <= left;
      right_q  <= right;
    end
  end

  // Free-running blink generator toggling every BLINK_HALF_CYCLES
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BlinkLast) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BlinkW'(1);
    end
  end

  // Lights are gated from registered sources so they clear with power
  always_comb begin
    state             = state_q;
    moving_state      = moving_q;
    power_light       = power;
    state_light       = power ? state_onehot(state_q) : 3'b000;
    moving_light      = moving_q;
    turn_left_light   = power & left_q & blink_q;
    turn_right_light  = power & right_q & blink_q;
  end

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// Randomized and directed bench for manual_drive_ctrl with a rule-level reference model.
module tb_manual_drive_ctrl;

  localparam int unsigned LONG  = 4;
  localparam int unsigned BHALF = 2;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       power_on = 0, power_off = 0, clutch = 0, throttle = 0;
  logic       brake = 0, rgs = 0, left = 0, right = 0;
  logic       power;
  logic [1:0] state;
  logic [3:0] moving_state, moving_light;
  logic       power_light, turn_left_light, turn_right_light;
  logic [2:0] state_light;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_power, m_state, m_hold, m_prev_rgs, m_edges;
  logic [3:0] m_moving;
  logic       m_left, m_right;

  manual_drive_ctrl #(
    .LONG_PRESS_CYCLES(LONG),
    .BLINK_HALF_CYCLES(BHALF)
  ) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .power_on        (power_on),
    .power_off       (power_off),
    .clutch          (clutch),
    .throttle        (throttle),
    .brake           (brake),
    .rgs             (rgs),
    .left            (left),
    .right           (right),
    .power           (power),
    .state           (state),
    .moving_state    (moving_state),
    .power_light     (power_light),
    .state_light     (state_light),
    .moving_light    (moving_light),
    .turn_left_light (turn_left_light),
    .turn_right_light(turn_right_light)
  );

  always #5 sys_clk = ~sys_clk;

  wire [16:0] dut_vec = {power, state, moving_state, power_light, state_light, moving_light,
                         turn_left_light, turn_right_light};

  function automatic logic [16:0] exp_vec();
    logic [2:0] sl;
    logic       blink;
    sl    = (m_power != 0) ? 3'(1 << m_state) : 3'b000;
    blink = ((m_edges / BHALF) % 2) == 1;
    return {m_power[0], 2'(m_state), m_moving, m_power[0], sl, m_moving,
            m_power[0] & m_left & blink, m_power[0] & m_right & blink};
  endfunction

  task automatic model_reset();
    m_power = 0; m_state = 0; m_hold = 0; m_prev_rgs = 0; m_edges = 0;
    m_moving = 4'b0; m_left = 0; m_right = 0;
  endtask

  // Apply the behavioural rules for one rising edge
  task automatic model_step();
    bit stall;
    int npower, nstate;
    stall = (m_power != 0) &&
            ((m_state == 0 && throttle && !clutch) ||
             (m_state != 0 && (int'(rgs) != m_prev_rgs) && !clutch));
    npower = m_power;
    if (power_off) begin
      npower = 0; m_hold = 0;
    end else if (m_power != 0) begin
      m_hold = 0;
      if (stall) npower = 0;
    end else if (power_on) begin
      m_hold++;
      if (m_hold == LONG) begin npower = 1; m_hold = 0; end
    end else begin
      m_hold = 0;
    end
    if (m_power == 0 || power_off || stall || brake) nstate = 0;
    else if (m_state == 0 && throttle && clutch)     nstate = 1;
    else if (m_state == 1 && throttle && !clutch)    nstate = 2;
    else if (m_state == 2 && (clutch || !throttle))  nstate = 1;
    else                                             nstate = m_state;
    m_moving   = (nstate == 2) ? {right & ~left, left & ~right, rgs, ~rgs} : 4'b0000;
    m_power    = npower;
    m_state    = nstate;
    m_prev_rgs = int'(rgs);
    m_left     = left;
    m_right    = right;
    m_edges++;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    power_on = 0; power_off = 0; clutch = 0; throttle = 0;
    brake = 0; rgs = 0; left = 0; right = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic power_up();
    power_on = 1;
    repeat (LONG) tick();
    power_on = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec !== 17'd0) begin
      $display("FAIL reset_outputs: got %b expected %b", dut_vec, 17'd0);
      errors++;
    end
  endtask

  task automatic test_long_press();
    power_on = 1;
    repeat (LONG - 1) begin
      tick();
      checks++;
      if (power !== 1'b0 || dut_vec !== exp_vec()) begin
        $display("FAIL short_press: got %b expected %b", dut_vec, exp_vec());
        errors++;
      end
    end
    power_on = 0;
    tick();
    power_on = 1;
    repeat (LONG) tick();
    power_on = 0;
    checks++;
    if (power !== 1'b1 || state_light !== 3'b001 || dut_vec !== exp_vec()) begin
      $display("FAIL long_press: got power=%b light=%b expected power=1 light=001", power,
               state_light);
      errors++;
    end
  endtask

  task automatic test_throttle_stall();
    throttle = 1; clutch = 0;
    tick();
    checks++;
    if (power !== 1'b0 || state !== 2'b00 || dut_vec !== exp_vec()) begin
      $display("FAIL throttle_stall: got %b expected %b", dut_vec, exp_vec());
      errors++;
    end
    throttle = 0;
    tick();
  endtask

  task automatic test_drive();
    int toggles;
    logic prev;
    power_up();
    clutch = 1; throttle = 1;
    tick();
    checks++;
    if (state !== 2'b01 || dut_vec !== exp_vec()) begin
      $display("FAIL drive_starting: got %b expected %b", dut_vec, exp_vec());
      errors++;
    end
    clutch = 0;
    tick();
    checks++;
    if (state !== 2'b10 || moving_state !== 4'b0001 || dut_vec !== exp_vec()) begin
      $display("FAIL drive_moving: got %b expected %b", dut_vec, exp_vec());
      errors++;
    end
    left = 1;
    tick();
    checks++;
    if (moving_state !== 4'b0101 || dut_vec !== exp_vec()) begin
      $display("FAIL drive_left: got %b expected %b", dut_vec, exp_vec());
      errors++;
    end
    toggles = 0;
    prev = turn_left_light;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (turn_left_light !== prev) toggles++;
      prev = turn_left_light;
      checks++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL turn_blink: got %b expected %b", dut_vec, exp_vec());
        errors++;
      end
    end
    checks++;
    if (toggles != 4) begin
      $display("FAIL blink_toggles: got %0d expected 4", toggles);
      errors++;
    end
    left = 1; right = 1;
    tick();
    checks++;
    if (moving_state !== 4'b0001 || dut_vec !== exp_vec()) begin
      $display("FAIL both_turn: got %b expected %b", dut_vec, exp_vec());
      errors++;
    end
    left = 0; right = 0;
  endtask

  task automatic test_gear_change();
    // Still MOVING from test_drive: gear change with clutch is a clean shift to STARTING
    clutch = 1; rgs = 1;
    tick();
    checks++;
    if (power !== 1'b1 || state !== 2'b01 || dut_vec !== exp_vec()) begin
      $display("FAIL gear_with_clutch: got %b expected %b", dut_vec, exp_vec());
      errors++;
    end
    clutch = 0;
    tick();
    checks++;
    if (state !== 2'b10 || moving_state !== 4'b0010 || dut_vec !== exp_vec()) begin
      $display("FAIL reverse_moving: got %b expected %b", dut_vec, exp_vec());
      errors++;
    end
    rgs = 0;
    tick();
    checks++;
    if (power !== 1'b0 || state !== 2'b00 || dut_vec !== exp_vec()) begin
      $display("FAIL gear_stall: got %b expected %b", dut_vec, exp_vec());
      errors++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_brake_and_off();
    power_up();
    clutch = 1; throttle = 1; tick();
    clutch = 0; tick();
    brake = 1;
    tick();
    checks++;
    if (state !== 2'b00 || moving_state !== 4'b0000 || power !== 1'b1 ||
        dut_vec !== exp_vec()) begin
      $display("FAIL brake: got %b expected %b", dut_vec, exp_vec());
      errors++;
    end
    clear_inputs();
    power_off = 1;
    tick();
    power_off = 0;
    power_on = 1;
    tick(); tick();
    power_off = 1;
    tick();
    checks++;
    if (power !== 1'b0 || dut_vec !== exp_vec()) begin
      $display("FAIL off_during_hold: got %b expected %b", dut_vec, exp_vec());
      errors++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    power_up();
    clutch = 1; throttle = 1; left = 1; tick();
    clutch = 0; tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 17'd0) begin
      $display("FAIL async_reset: got %b expected %b", dut_vec, 17'd0);
      errors++;
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      power_on  = ($urandom % 8) != 0;
      power_off = ($urandom % 32) == 0;
      clutch    = 1'($urandom % 2);
      throttle  = ($urandom % 4) != 0;
      brake     = ($urandom % 16) == 0;
      if (($urandom % 16) == 0) rgs = ~rgs;
      left      = 1'($urandom % 2);
      right     = 1'($urandom % 2);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL random_step%0d: got %b expected %b", i, dut_vec, exp_vec());
        errors++;
      end
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_long_press();
    test_throttle_stall();
    test_drive();
    test_gear_change();
    test_brake_and_off();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
